// File: rtl/grf_writeback_if.sv
// Decoder/datapath-facing bundle of the register file: instruction fields, write-back controls, read ports and trace.
// The master drives the instruction and controls; the slave (register file) drives the reads and the trace.
interface grf_writeback_if;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        RegWrite;
  logic [1:0]  RegDst;
  logic [1:0]  MemtoReg;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  modport master (
    output instr, pc, RegWrite, RegDst, MemtoReg, alu_result, mem_rdata,
    input  rd1, rd2, wb_valid, wb_pc, wb_addr, wb_data
  );

  modport slave (
    input  instr, pc, RegWrite, RegDst, MemtoReg, alu_result, mem_rdata,
    output rd1, rd2, wb_valid, wb_pc, wb_addr, wb_data
  );
endinterface

// File: rtl/grf_writeback.sv
// 32x32 GPR file with write-back select: writes commit on the rising edge, reads are combinational.
// The trace registers one pulse per attempted write (including dropped $0 writes); no backpressure.
module grf_writeback #(
  parameter logic [31:0] PC_INIT = 32'h0000_3000,
  parameter bit          BYPASS  = 1'b0
) (
  input logic            clk,
  input logic            reset,
  grf_writeback_if.slave bus
);

  if (PC_INIT[1:0] != 2'b00) begin : g_pc_init_check
    $error("PC_INIT must be word aligned");
  end

  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pc_plus4;
  logic        we;
  logic [31:0] rd1_val;
  logic [31:0] rd2_val;

  logic [31:0] gpr_q [32];
  logic [31:0] gpr_d [32];
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_pc_q,    wb_pc_d;
  logic [4:0]  wb_addr_q,  wb_addr_d;
  logic [31:0] wb_data_q,  wb_data_d;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr[31:26], bus.instr[10:0]};

  always_comb begin
    rs       = bus.instr[25:21];
    rt       = bus.instr[20:16];
    rd       = bus.instr[15:11];
    pc_plus4 = bus.pc + 32'd4;

    waddr = rt;
    case (bus.RegDst)
      2'b00:   waddr = rt;
      2'b01:   waddr = rd;
      2'b10:   waddr = 5'd31;
      default: waddr = 5'd0;
    endcase

    wdata = bus.alu_result;
    case (bus.MemtoReg)
      2'b00:   wdata = bus.alu_result;
      2'b01:   wdata = bus.mem_rdata;
      2'b10:   wdata = pc_plus4;
      default: wdata = 32'd0;
    endcase

    // Reserved encodings kill the whole write, trace included.
    we = bus.RegWrite & ~reset & (bus.RegDst != 2'b11) & (bus.MemtoReg != 2'b11);
  end

  always_comb begin
    gpr_d = gpr_q;
    if (we && waddr != 5'd0) begin
      gpr_d[waddr] = wdata;
    end

    wb_valid_d = we;
    wb_pc_d    = wb_pc_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (we) begin
      wb_pc_d   = bus.pc;
      wb_addr_d = waddr;
      wb_data_d = wdata;
    end
  end

  always_comb begin
    rd1_val = gpr_q[rs];
    if (rs == 5'd0) begin
      rd1_val = 32'd0;
    end else if (BYPASS && we && waddr == rs) begin
      rd1_val = wdata;
    end

    rd2_val = gpr_q[rt];
    if (rt == 5'd0) begin
      rd2_val = 32'd0;
    end else if (BYPASS && we && waddr == rt) begin
      rd2_val = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= 32'd0;
      end
      wb_valid_q <= 1'b0;
      wb_pc_q    <= 32'd0;
      wb_addr_q  <= 5'd0;
      wb_data_q  <= 32'd0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= gpr_d[i];
      end
      wb_valid_q <= wb_valid_d;
      wb_pc_q    <= wb_pc_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign bus.rd1      = rd1_val;
  assign bus.rd2      = rd2_val;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_pc    = wb_pc_q;
  assign bus.wb_addr  = wb_addr_q;
  assign bus.wb_data  = wb_data_q;

endmodule

// File: tb/tb_grf_writeback.sv
// Directed bench driving a BYPASS=0 and a BYPASS=1 instance with identical stimulus.
module tb_grf_writeback;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;

  int err_cnt;
  int chk_cnt;

  grf_writeback_if b0 ();
  grf_writeback_if b1 ();

  assign b0.instr = instr;      assign b1.instr = instr;
  assign b0.pc = pc;            assign b1.pc = pc;
  assign b0.RegWrite = reg_write;  assign b1.RegWrite = reg_write;
  assign b0.RegDst = reg_dst;      assign b1.RegDst = reg_dst;
  assign b0.MemtoReg = mem_to_reg; assign b1.MemtoReg = mem_to_reg;
  assign b0.alu_result = alu_result; assign b1.alu_result = alu_result;
  assign b0.mem_rdata = mem_rdata;   assign b1.mem_rdata = mem_rdata;

  grf_writeback #(.PC_INIT(32'h0000_3000), .BYPASS(1'b0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  grf_writeback #(.PC_INIT(32'h0000_3000), .BYPASS(1'b1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 11'd0};
  endfunction

  task automatic drv(input logic we, input logic [1:0] dst, input logic [1:0] m2r,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] p);
    reg_write  = we;
    reg_dst    = dst;
    mem_to_reg = m2r;
    instr      = mk(rs, rt, rd);
    alu_result = alu;
    mem_rdata  = mem;
    pc         = p;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_trace(input string tag, input logic v, input logic [31:0] p,
                           input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".valid0"}, b0.wb_valid, v);
    chk({tag, ".valid1"}, b1.wb_valid, v);
    chk({tag, ".pc"},     b0.wb_pc, p);
    chk({tag, ".addr"},   b0.wb_addr, a);
    chk({tag, ".data"},   b0.wb_data, d);
    chk({tag, ".data1"},  b1.wb_data, d);
  endtask

  task automatic chk_rd1(input string tag, input logic [31:0] e0, input logic [31:0] e1);
    chk({tag, ".rd1_b0"}, b0.rd1, e0);
    chk({tag, ".rd1_b1"}, b1.rd1, e1);
  endtask

  initial begin
    err_cnt = 0;
    chk_cnt = 0;

    // Reset held two cycles while a write is requested.
    reset = 1'b1;
    drv(1'b1, 2'b01, 2'b00, 5'd8, 5'd8, 5'd8, 32'hFFFF_FFFF, 32'h0, 32'h3000);
    chk_rd1("rst_comb", 32'h0, 32'h0);
    step();
    step();
    chk_trace("rst", 1'b0, 32'h0, 5'd0, 32'h0);
    chk_rd1("rst_rd", 32'h0, 32'h0);

    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      drv(1'b0, 2'b01, 2'b00, a[4:0], 5'(31 - a), 5'd0, 32'h0, 32'h0, 32'h3000);
      chk($sformatf("rd1_a%0d", a), b0.rd1, 32'h0);
      chk($sformatf("rd2_a%0d", 31 - a), b1.rd2, 32'h0);
    end

    // ALU write to $8.
    drv(1'b1, 2'b01, 2'b00, 5'd8, 5'd0, 5'd8, 32'h1234_5678, 32'h0, 32'h0000_3000);
    chk_rd1("alu_same", 32'h0, 32'h1234_5678);
    step();
    drv(1'b0, 2'b01, 2'b00, 5'd8, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0000_3004);
    chk_trace("alu_tr", 1'b1, 32'h3000, 5'd8, 32'h1234_5678);
    chk_rd1("alu_next", 32'h1234_5678, 32'h1234_5678);
    step();
    chk_trace("idle_hold", 1'b0, 32'h3000, 5'd8, 32'h1234_5678);

    // Load into rt=$9.
    drv(1'b1, 2'b00, 2'b01, 5'd8, 5'd9, 5'd3, 32'h5555_5555, 32'hDEAD_BEEF, 32'h0000_3004);
    step();
    drv(1'b0, 2'b00, 2'b00, 5'd9, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0000_3008);
    chk_trace("ld_tr", 1'b1, 32'h3004, 5'd9, 32'hDEAD_BEEF);
    chk_rd1("ld_rd", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    chk("ld_rd2", b0.rd2, 32'h1234_5678);

    // jal links pc+4 into $31, including the wrap case.
    drv(1'b1, 2'b10, 2'b10, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0000_3010);
    step();
    drv(1'b0, 2'b00, 2'b00, 5'd31, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0000_3014);
    chk_trace("jal_tr", 1'b1, 32'h3010, 5'd31, 32'h3014);
    chk_rd1("jal_rd", 32'h3014, 32'h3014);
    drv(1'b1, 2'b10, 2'b10, 5'd31, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFC);
    step();
    drv(1'b0, 2'b00, 2'b00, 5'd31, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0000_3018);
    chk_trace("jalw_tr", 1'b1, 32'hFFFF_FFFC, 5'd31, 32'h0);
    chk_rd1("jalw_rd", 32'h0, 32'h0);

    // $0 write is dropped but traced.
    drv(1'b1, 2'b01, 2'b00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0000_3020);
    chk_rd1("z_same", 32'h0, 32'h0);
    step();
    drv(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0000_3024);
    chk_trace("z_tr", 1'b1, 32'h3020, 5'd0, 32'hFFFF_FFFF);
    chk_rd1("z_rd", 32'h0, 32'h0);

    // Reserved RegDst, then reserved MemtoReg: nothing changes.
    drv(1'b1, 2'b11, 2'b00, 5'd9, 5'd9, 5'd9, 32'h1111_1111, 32'h0, 32'h0000_3030);
    chk_rd1("rsv1_same", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    step();
    chk_trace("rsv1_tr", 1'b0, 32'h3020, 5'd0, 32'hFFFF_FFFF);
    chk_rd1("rsv1_rd", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    drv(1'b1, 2'b01, 2'b11, 5'd9, 5'd9, 5'd9, 32'h2222_2222, 32'h3333_3333, 32'h0000_3034);
    chk_rd1("rsv2_same", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    step();
    drv(1'b0, 2'b00, 2'b00, 5'd9, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0000_3038);
    chk_trace("rsv2_tr", 1'b0, 32'h3020, 5'd0, 32'hFFFF_FFFF);
    chk_rd1("rsv2_rd", 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Same-cycle read of $5 with and without bypass.
    drv(1'b1, 2'b01, 2'b00, 5'd0, 5'd0, 5'd5, 32'h0000_0055, 32'h0, 32'h0000_3040);
    step();
    drv(1'b1, 2'b01, 2'b00, 5'd5, 5'd5, 5'd5, 32'hA5A5_A5A5, 32'h0, 32'h0000_3044);
    chk_rd1("byp_same", 32'h0000_0055, 32'hA5A5_A5A5);
    chk("byp_rd2_b0", b0.rd2, 32'h0000_0055);
    chk("byp_rd2_b1", b1.rd2, 32'hA5A5_A5A5);
    step();
    drv(1'b0, 2'b00, 2'b00, 5'd5, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0000_3048);
    chk_trace("byp_tr", 1'b1, 32'h3044, 5'd5, 32'hA5A5_A5A5);
    chk_rd1("byp_next", 32'hA5A5_A5A5, 32'hA5A5_A5A5);

    // Back-to-back writes to $6: last edge wins, one pulse each.
    drv(1'b1, 2'b01, 2'b00, 5'd6, 5'd0, 5'd6, 32'h0000_0001, 32'h0, 32'h0000_3050);
    step();
    chk_trace("b2b1_tr", 1'b1, 32'h3050, 5'd6, 32'h1);
    drv(1'b1, 2'b01, 2'b00, 5'd6, 5'd0, 5'd6, 32'h0000_0002, 32'h0, 32'h0000_3054);
    chk_rd1("b2b_mid", 32'h1, 32'h2);
    step();
    drv(1'b0, 2'b00, 2'b00, 5'd6, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0000_3058);
    chk_trace("b2b2_tr", 1'b1, 32'h3054, 5'd6, 32'h2);
    chk_rd1("b2b_rd", 32'h2, 32'h2);

    // Mid-stream reset with a concurrent write; write after release commits.
    reset = 1'b1;
    drv(1'b1, 2'b01, 2'b00, 5'd7, 5'd0, 5'd7, 32'h0000_0077, 32'h0, 32'h0000_3060);
    chk_rd1("mrst_same", 32'h0, 32'h0);
    step();
    reset = 1'b0;
    drv(1'b0, 2'b00, 2'b00, 5'd5, 5'd7, 5'd0, 32'h0, 32'h0, 32'h0000_3064);
    chk_trace("mrst_tr", 1'b0, 32'h0, 5'd0, 32'h0);
    chk_rd1("mrst_r5", 32'h0, 32'h0);
    chk("mrst_r7", b0.rd2, 32'h0);
    drv(1'b1, 2'b01, 2'b00, 5'd7, 5'd0, 5'd7, 32'h0000_0077, 32'h0, 32'h0000_3068);
    step();
    drv(1'b0, 2'b00, 2'b00, 5'd7, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0000_306C);
    chk_trace("post_tr", 1'b1, 32'h3068, 5'd7, 32'h77);
    chk_rd1("post_rd", 32'h77, 32'h77);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/grf_writeback.md
Name: grf_writeback

Overview:
- 32 x 32-bit general register file with an integrated write-back selector for the single-cycle MIPS core.
- Consumes the decoder's register-side control outputs: RegWrite, RegDst and MemtoReg.
- Resolves the destination register and write data, commits on the clock edge, and serves two combinational read ports to the ALU and branch compare.
- Emits a registered write-back trace for the verification log.

Parameters:
- PC_INIT, 32'h0000_3000, reset PC value; used only to document trace alignment, not stored.
- BYPASS, 0, 1 = a read of the register being written this cycle returns the new data; 0 = a read returns the old contents.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  synchronous, active-high reset
- instr  input  32  current instruction; rs=[25:21], rt=[20:16], rd=[15:11]
- pc  input  32  PC of the current instruction
- RegWrite  input  1  write enable from the decoder
- RegDst  input  2  destination select: 00 rt, 01 rd, 10 $31, 11 reserved
- MemtoReg  input  2  data select: 00 alu_result, 01 mem_rdata, 10 pc+4, 11 reserved
- alu_result  input  32  ALU output
- mem_rdata  input  32  data memory read data
- rd1  output  32  contents of GPR[rs]
- rd2  output  32  contents of GPR[rt]
- wb_valid  output  1  registered pulse, high for the cycle after a committed write
- wb_pc  output  32  PC of the committed write
- wb_addr  output  5  destination of the committed write
- wb_data  output  32  data of the committed write

Behaviour:
- Clock and reset: single clock domain, reset sampled only at the rising clk edge.
- Reset effect, at the edge where reset=1:
  - All 32 GPRs clear to 0.
  - wb_valid=0, wb_pc=0, wb_addr=0, wb_data=0.
  - Any write requested in the same cycle is discarded; reset dominates.
- Destination select (combinational): waddr = rt / rd / 5'd31 by RegDst.
- Write data select (combinational): wdata = alu_result / mem_rdata / pc+4 by MemtoReg.
  - pc+4 is a 32-bit add and wraps modulo 2^32 (pc=32'hFFFF_FFFC gives 0).
- Write enable: we = RegWrite & ~reset & (RegDst != 11) & (MemtoReg != 11). Reserved encodings suppress the write entirely; no partial update occurs.
- Commit: on a clk edge with we=1 and waddr != 0, GPR[waddr] <= wdata. Latency is one edge; the value is visible on reads starting the next cycle.
- Register $0:
  - Writes to $0 are dropped, and GPR[0] always reads 0.
  - A dropped $0 write still produces a trace: wb_valid=1, wb_addr=0, wb_data=wdata. This matches the reference simulator's log of attempted writes.
- Read ports (combinational):
  - rd1 = GPR[rs] and rd2 = GPR[rt]; address 0 returns 0.
  - With BYPASS=1, when we=1, waddr != 0 and a read address equals waddr, that port returns wdata in the same cycle.
  - With BYPASS=0, that port returns the old value.
- Trace, registered on the commit edge:
  - wb_valid <= we.
  - When we=1: wb_pc <= pc, wb_addr <= waddr, wb_data <= wdata.
  - When we=0: wb_pc, wb_addr and wb_data hold their previous values.
- Back-to-back writes to the same register: the last edge wins; each write produces its own trace pulse.
- Reset asserted mid-stream clears the state on that edge. The first write after reset deasserts commits normally on the following edge.

Test Plan:
- Reset and read: reset high for 2 cycles with RegWrite=1 -> all reads 0, wb_valid=0, no trace; then read every address -> 0.
- ALU write: RegWrite=1, RegDst=01, rd=8, MemtoReg=00, alu_result=32'h1234_5678, pc=32'h3000 -> next cycle rd1 (rs=8) = 32'h1234_5678; trace shows wb_valid=1, wb_pc=3000, wb_addr=8, wb_data=12345678.
- Load and jal: RegDst=00, rt=9, MemtoReg=01, mem_rdata=32'hDEAD_BEEF -> GPR9=DEADBEEF. Then RegDst=10, MemtoReg=10, pc=32'h3010 -> GPR31=32'h3014. Also check pc=FFFF_FFFC -> GPR31=0.
- $0 protection: write 32'hFFFF_FFFF to rd=0 -> rd1 (rs=0) stays 0; trace pulse shows addr 0, data FFFFFFFF.
- Reserved encodings: RegDst=11 or MemtoReg=11 with RegWrite=1 -> no register changes, wb_valid=0.
- Same-cycle read of the written register: write 32'hA5A5_A5A5 to $5 while rs=5. BYPASS=0 -> rd1 shows the old value that cycle. BYPASS=1 -> rd1 = A5A5A5A5 that cycle. Both configurations show the new value on the next cycle.
